// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/handshake inputs and datapath controls between controller and datapath
interface multicycle_ctrl_if #(parameter int STEP_W = 32);
  logic [6:0] op;
  logic [24:0] rest_instr;
  logic uart_done, flpt_done;
  logic pcwrite, memwrite, irwrite, regwrite, fregwrite, pcbufwrite, iord, branch;
  logic [1:0] alusrca, alusrcb, pcsrc;
  logic [2:0] regsrc, aluop;
  logic uart_go, rors, iorf, indecode, timeout_err;
  logic [STEP_W-1:0] steps;
  modport master (
    output op, rest_instr, uart_done, flpt_done,
    input pcwrite, memwrite, irwrite, regwrite, fregwrite, pcbufwrite, iord, branch,
    input alusrca, alusrcb, pcsrc, regsrc, aluop, uart_go, rors, iorf, indecode, timeout_err, steps
  );
  modport slave (
    input op, rest_instr, uart_done, flpt_done,
    output pcwrite, memwrite, irwrite, regwrite, fregwrite, pcbufwrite, iord, branch,
    output alusrca, alusrcb, pcsrc, regsrc, aluop, uart_go, rors, iorf, indecode, timeout_err, steps
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RISC-V style control FSM with memory latency, UART/FPU waits and step counter
module multicycle_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int WAIT_TO = 0,
  parameter int STEP_W  = 32
) (
  input logic clk,
  input logic rstn,
  multicycle_ctrl_if.slave bus
);
  localparam logic [6:0] RTYPE = 7'b0110011, ITYPE = 7'b0010011, BTYPE = 7'b1100011,
    LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111,
    LW = 7'b0000011, SW = 7'b0100011, RECVB = 7'b0000001, SENDB = 7'b0000010,
    FLW = 7'b0000111, FSW = 7'b0100111, FTYPE = 7'b1010011;
  localparam int MX = WAIT_TO > MEM_LAT ? WAIT_TO : MEM_LAT;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [4:0] {
    FETCH, FWAIT, FVALID, DECODE, MEMADR, MREAD, MVALID, MWB, FMWB, MWRITE,
    EXEC, IEXEC, ALUWB, IWB, AUIPCS, LUIS, BRANCH, JALS, JALRS,
    SEND_GO, SEND_WAIT, RECV_GO, RECV_WAIT, RECV_WB, FEXEC
  } state_t;
  typedef struct packed {
    logic pcwrite, memwrite, irwrite, regwrite, fregwrite, pcbufwrite, iord, branch;
    logic uart_go, rors, indecode, mwr;
    logic [1:0] alusrca, alusrcb, pcsrc;
    logic [2:0] regsrc, aluop;
  } out_t;
  function automatic out_t dec(state_t s);
    out_t o = '0;
    case (s)
      FETCH:     begin o.pcwrite = 1'b1; o.pcbufwrite = 1'b1; o.alusrcb = 2'b01; end
      FVALID:    o.irwrite = 1'b1;
      DECODE:    begin o.alusrca = 2'b01; o.alusrcb = 2'b10; o.indecode = 1'b1; end
      MEMADR:    begin o.alusrca = 2'b10; o.alusrcb = 2'b10; end
      MREAD:     o.iord = 1'b1;
      MVALID:    o.iord = 1'b1;
      MWB:       begin o.regwrite = 1'b1; o.regsrc = 3'b001; end
      FMWB:      o.fregwrite = 1'b1;
      MWRITE:    begin o.memwrite = 1'b1; o.iord = 1'b1; o.mwr = 1'b1; end
      EXEC:      begin o.alusrca = 2'b10; o.aluop = 3'b100; end
      IEXEC:     begin o.alusrca = 2'b10; o.alusrcb = 2'b10; o.aluop = 3'b101; end
      ALUWB:     o.regwrite = 1'b1;
      IWB:       o.regwrite = 1'b1;
      AUIPCS:    o.regwrite = 1'b1;
      LUIS:      begin o.regwrite = 1'b1; o.regsrc = 3'b010; end
      BRANCH:    begin o.alusrca = 2'b10; o.pcsrc = 2'b01; o.branch = 1'b1; o.aluop = 3'b111; end
      JALS:      begin o.pcwrite = 1'b1; o.regwrite = 1'b1; o.regsrc = 3'b011; o.pcsrc = 2'b01; end
      JALRS:     begin
        o.pcwrite = 1'b1; o.regwrite = 1'b1; o.alusrca = 2'b10; o.alusrcb = 2'b10;
        o.regsrc = 3'b011; o.pcsrc = 2'b10;
      end
      SEND_GO:   begin o.uart_go = 1'b1; o.rors = 1'b1; end
      RECV_GO:   o.uart_go = 1'b1;
      RECV_WB:   begin o.regwrite = 1'b1; o.regsrc = 3'b100; end
      default:   ;
    endcase
    return o;
  endfunction
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [STEP_W-1:0] steps_q;
  logic terr_q, tmo, terr_set;
  out_t out_q;
  always_comb begin
    state_d = FETCH;
    tmo = WAIT_TO > 0 && cnt_q == CW'(WAIT_TO - 1);
    case (state_q)
      FETCH:     state_d = MEM_LAT > 1 ? FWAIT : FVALID;
      FWAIT:     state_d = cnt_q == CW'(MEM_LAT - 2) ? FVALID : FWAIT;
      FVALID:    state_d = DECODE;
      DECODE:
        case (bus.op)
          LW, SW, FLW, FSW: state_d = MEMADR;
          RTYPE:   state_d = bus.rest_instr == '0 ? FETCH : EXEC;
          ITYPE:   state_d = IEXEC;
          BTYPE:   state_d = BRANCH;
          LUI:     state_d = LUIS;
          AUIPC:   state_d = AUIPCS;
          JAL:     state_d = JALS;
          JALR:    state_d = JALRS;
          SENDB:   state_d = SEND_GO;
          RECVB:   state_d = RECV_GO;
          FTYPE:   state_d = FEXEC;
          default: state_d = FETCH;
        endcase
      MEMADR:    state_d = (bus.op == LW || bus.op == FLW) ? MREAD :
                           (bus.op == SW || bus.op == FSW) ? MWRITE : FETCH;
      MREAD:     state_d = cnt_q == CW'(MEM_LAT - 1) ? MVALID : MREAD;
      MVALID:    state_d = bus.op == FLW ? FMWB : MWB;
      EXEC:      state_d = ALUWB;
      IEXEC:     state_d = IWB;
      SEND_GO:   state_d = SEND_WAIT;
      RECV_GO:   state_d = RECV_WAIT;
      SEND_WAIT: state_d = (bus.uart_done || tmo) ? FETCH : SEND_WAIT;
      RECV_WAIT: state_d = bus.uart_done ? RECV_WB : tmo ? FETCH : RECV_WAIT;
      FEXEC:     state_d = (bus.flpt_done || tmo) ? FETCH : FEXEC;
      default:   state_d = FETCH;
    endcase
    terr_set = tmo && (((state_q == SEND_WAIT || state_q == RECV_WAIT) && !bus.uart_done) ||
                       (state_q == FEXEC && !bus.flpt_done));
    cnt_d = state_d == state_q ? cnt_q + CW'(1) : '0;
  end
  // outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      steps_q <= '0;
      terr_q  <= 1'b0;
      out_q   <= dec(FETCH);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_q + STEP_W'(state_q == FETCH);
      terr_q  <= terr_q | terr_set;
      out_q   <= dec(state_d);
    end
  assign bus.pcwrite     = out_q.pcwrite;
  assign bus.memwrite    = out_q.memwrite;
  assign bus.irwrite     = out_q.irwrite;
  assign bus.regwrite    = out_q.regwrite;
  assign bus.fregwrite   = out_q.fregwrite;
  assign bus.pcbufwrite  = out_q.pcbufwrite;
  assign bus.iord        = out_q.iord;
  assign bus.branch      = out_q.branch;
  assign bus.alusrca     = out_q.alusrca;
  assign bus.alusrcb     = out_q.alusrcb;
  assign bus.pcsrc       = out_q.pcsrc;
  assign bus.regsrc      = out_q.regsrc;
  assign bus.aluop       = out_q.aluop;
  assign bus.uart_go     = out_q.uart_go;
  assign bus.rors        = out_q.rors;
  assign bus.indecode    = out_q.indecode;
  assign bus.iorf        = out_q.mwr & (bus.op == FSW);
  assign bus.timeout_err = terr_q;
  assign bus.steps       = steps_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard of expected per-cycle control words for three parameterisations
module tb_multicycle_ctrl;
  localparam logic [6:0] RTYPE = 7'b0110011, LW = 7'b0000011, FSW = 7'b0100111,
    RECVB = 7'b0000001, SENDB = 7'b0000010, BAD = 7'b1111111;
  logic clk = 1'b0, rstn = 1'b0, ud = 1'b0, fd = 1'b0;
  logic [6:0] op = '0;
  logic [24:0] rest = '0;
  logic [24:0] obs [3];
  logic [3:0] stp [3];
  logic terr [3];
  int errs = 0, checks = 0;
  typedef struct {int d; string tag; logic [24:0] v;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  // dut0: MEM_LAT=2 WAIT_TO=5, dut1: MEM_LAT=1, dut2: MEM_LAT=4; all STEP_W=4
  for (genvar g = 0; g < 3; g++) begin : u
    multicycle_ctrl_if #(.STEP_W(4)) bus ();
    multicycle_ctrl #(.MEM_LAT(g == 0 ? 2 : g == 1 ? 1 : 4), .WAIT_TO(g == 0 ? 5 : 0), .STEP_W(4))
      dut (.clk(clk), .rstn(rstn), .bus(bus));
    assign bus.op = op;
    assign bus.rest_instr = rest;
    assign bus.uart_done = ud;
    assign bus.flpt_done = fd;
    assign obs[g] = {bus.pcwrite, bus.memwrite, bus.irwrite, bus.regwrite, bus.fregwrite,
                     bus.pcbufwrite, bus.iord, bus.branch, bus.alusrca, bus.alusrcb, bus.pcsrc,
                     bus.regsrc, bus.aluop, bus.uart_go, bus.rors, bus.iorf, bus.indecode};
    assign stp[g] = bus.steps;
    assign terr[g] = bus.timeout_err;
  end
  function automatic logic [24:0] ov(string s, logic [6:0] o);
    logic pw, mw, ir, rw, fw, pb, io, br, ug, rs, fr, id;
    logic [1:0] sa, sb, ps;
    logic [2:0] rg, ao;
    {pw, mw, ir, rw, fw, pb, io, br, ug, rs, fr, id} = '0;
    {sa, sb, ps, rg, ao} = '0;
    case (s)
      "FETCH":   begin pw = 1; pb = 1; sb = 2'b01; end
      "FVALID":  ir = 1;
      "DECODE":  begin sa = 2'b01; sb = 2'b10; id = 1; end
      "MEMADR":  begin sa = 2'b10; sb = 2'b10; end
      "MREAD":   io = 1;
      "MVALID":  io = 1;
      "MWB":     begin rw = 1; rg = 3'b001; end
      "MWRITE":  begin mw = 1; io = 1; fr = (o == FSW); end
      "EXEC":    begin sa = 2'b10; ao = 3'b100; end
      "ALUWB":   rw = 1;
      "SEND_GO": begin ug = 1; rs = 1; end
      "RECV_GO": ug = 1;
      "RECV_WB": begin rw = 1; rg = 3'b100; end
      default:   ;
    endcase
    return {pw, mw, ir, rw, fw, pb, io, br, sa, sb, ps, rg, ao, ug, rs, fr, id};
  endfunction
  task automatic push(int d, string s, int n = 1);
    for (int i = 0; i < n; i++) q.push_back('{d, s, ov(s, op)});
  endtask
  task automatic drain(int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      #1;
      checks++;
      if (q.size() == 0) begin
        errs++;
        $error("FAIL scoreboard empty: got nothing expected entry");
      end else begin
        e = q.pop_front();
        assert (obs[e.d] === e.v) else begin
          errs++;
          $error("FAIL %s dut%0d: got %h expected %h", e.tag, e.d, obs[e.d], e.v);
        end
      end
      @(negedge clk);
    end
  endtask
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic reset_pulse();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out", 32'(obs[0]), 32'(ov("FETCH", op)));
    chk("reset_steps", 32'(stp[0]), 0);
    chk("reset_terr", 32'(terr[0]), 0);
    // LW with MEM_LAT=2
    op = LW; rest = 25'h1;
    @(negedge clk);
    rstn = 1'b1;
    push(0, "FETCH"); push(0, "FWAIT"); push(0, "FVALID"); push(0, "DECODE"); push(0, "MEMADR");
    push(0, "MREAD", 2); push(0, "MVALID"); push(0, "MWB"); push(0, "FETCH");
    drain(8);
    #1 chk("lw_steps", 32'(stp[0]), 1);
    drain(2);
    // FSW with MEM_LAT=1 and MEM_LAT=4
    op = FSW;
    reset_pulse();
    push(1, "FETCH"); push(1, "FVALID"); push(1, "DECODE"); push(1, "MEMADR"); push(1, "MWRITE");
    push(1, "FETCH");
    drain(6);
    reset_pulse();
    push(2, "FETCH"); push(2, "FWAIT", 3); push(2, "FVALID"); push(2, "DECODE"); push(2, "MEMADR");
    push(2, "MWRITE"); push(2, "FETCH");
    drain(9);
    // RTYPE NOP then real RTYPE
    op = RTYPE; rest = '0;
    reset_pulse();
    push(0, "FETCH"); push(0, "FWAIT"); push(0, "FVALID"); push(0, "DECODE"); push(0, "FETCH");
    push(0, "FWAIT");
    drain(6);
    rest = 25'h155;
    push(0, "FVALID"); push(0, "DECODE"); push(0, "EXEC"); push(0, "ALUWB"); push(0, "FETCH");
    drain(5);
    // SENDB with done already high
    op = SENDB; ud = 1'b1;
    reset_pulse();
    push(0, "FETCH"); push(0, "FWAIT"); push(0, "FVALID"); push(0, "DECODE"); push(0, "SEND_GO");
    push(0, "SEND_WAIT"); push(0, "FETCH");
    drain(7);
    ud = 1'b0;
    // RECVB timeout, then LW interrupted by reset in MREAD
    op = RECVB;
    reset_pulse();
    push(0, "FETCH"); push(0, "FWAIT"); push(0, "FVALID"); push(0, "DECODE"); push(0, "RECV_GO");
    push(0, "RECV_WAIT", 5);
    drain(10);
    #1 chk("timeout_set", 32'(terr[0]), 1);
    op = LW;
    push(0, "FETCH"); push(0, "FWAIT"); push(0, "FVALID"); push(0, "DECODE"); push(0, "MEMADR");
    push(0, "MREAD");
    drain(6);
    #1 chk("pre_rst_steps", 32'(stp[0]), 2);
    chk("pre_rst_terr", 32'(terr[0]), 1);
    rstn = 1'b0;
    #1 chk("async_rst_out", 32'(obs[0]), 32'(ov("FETCH", op)));
    chk("async_rst_steps", 32'(stp[0]), 0);
    chk("async_rst_terr", 32'(terr[0]), 0);
    @(negedge clk);
    rstn = 1'b1;
    // RECVB with done arriving in the last wait cycle
    op = RECVB;
    reset_pulse();
    push(0, "FETCH"); push(0, "FWAIT"); push(0, "FVALID"); push(0, "DECODE"); push(0, "RECV_GO");
    push(0, "RECV_WAIT", 4);
    drain(9);
    ud = 1'b1;
    push(0, "RECV_WAIT"); push(0, "RECV_WB"); push(0, "FETCH");
    drain(3);
    ud = 1'b0;
    #1 chk("done_no_terr", 32'(terr[0]), 0);
    // steps wrap at STEP_W=4 with unknown opcodes
    op = BAD;
    @(negedge clk);
    reset_pulse();
    push(0, "FETCH"); push(0, "FWAIT"); push(0, "FVALID"); push(0, "DECODE"); push(0, "FETCH");
    drain(5);
    repeat (55) @(negedge clk);
    #1 chk("steps_15", 32'(stp[0]), 15);
    repeat (4) @(negedge clk);
    #1 chk("steps_wrap", 32'(stp[0]), 0);
    chk("queue_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 2: cycles from memory request to data valid, legal range 1..15.
REQ-002 Parameter WAIT_TO, default 0: timeout in cycles for UART and FPU wait states; 0 disables the timeout.
REQ-003 Parameter STEP_W, default 32: width of the instruction step counter.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rstn  in  1  reset; asynchronous, active-low.
REQ-006 op  in  7  opcode field of the instruction register.
REQ-007 rest_instr  in  25  instruction bits [31:7]; all-zero marks a NOP.
REQ-008 uart_done  in  1  UART transfer complete, level.
REQ-009 flpt_done  in  1  FPU operation complete, level.
REQ-010 pcwrite, memwrite, irwrite, regwrite, fregwrite, pcbufwrite, iord, branch  out  1 each  datapath strobes/selects.
REQ-011 alusrca  out  2 | alusrcb  out  2 | pcsrc  out  2 | regsrc  out  3 | aluop  out  3  datapath mux selects.
REQ-012 uart_go  out  1  UART start pulse; rors  out  1  1 = send, 0 = receive.
REQ-013 iorf  out  1  store data taken from the FP register file; indecode  out  1  high in DECODE.
REQ-014 timeout_err  out  1  sticky flag: a wait state timed out.
REQ-015 steps  out  STEP_W  count of FETCH cycles.

Function
REQ-016 Opcodes SHALL be RTYPE 0110011, ITYPE 0010011, BTYPE 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LW 0000011, SW 0100011, RECVB 0000001, SENDB 0000010, FLW 0000111, FSW 0100111, FTYPE 1010011.
REQ-017 Fetch SHALL run FETCH (1 cycle) -> FWAIT (MEM_LAT-1 cycles; skipped when MEM_LAT=1) -> FVALID (1 cycle) -> DECODE.
REQ-018 DECODE SHALL branch on op as follows:
- LW/SW/FLW/FSW -> MEMADR.
- RTYPE -> EXEC, or FETCH when rest_instr==0.
- ITYPE->IEXEC, BTYPE->BRANCH, LUI->LUIS, AUIPC->AUIPCS, JAL->JALS, JALR->JALRS.
- SENDB->SEND_GO, RECVB->RECV_GO, FTYPE->FEXEC.
- Any other op -> FETCH.
REQ-019 Memory and ALU sequences SHALL be:
- MEMADR -> MREAD for LW/FLW, MWRITE for SW/FSW, FETCH otherwise.
- MREAD (MEM_LAT cycles) -> MVALID (1 cycle) -> FMWB for FLW, MWB otherwise.
- EXEC->ALUWB, IEXEC->IWB, SEND_GO->SEND_WAIT, RECV_GO->RECV_WAIT, RECV_WAIT on exit via done -> RECV_WB.
- All other states -> FETCH.
REQ-020 SEND_WAIT, RECV_WAIT and FEXEC SHALL exit on done (uart_done or flpt_done); done has priority over timeout in the same cycle.
REQ-021 With WAIT_TO>0, a wait state still not done after WAIT_TO cycles SHALL go to FETCH and set timeout_err; RECV_WB is skipped, so there is no regwrite.
REQ-022 One MEM_LAT/WAIT_TO counter SHALL clear on every state entry.
REQ-023 Outputs SHALL be Moore-decoded from state; every output not listed for a state is 0:
- FETCH: pcwrite, pcbufwrite, alusrcb=01. FVALID: irwrite.
- DECODE: alusrca=01, alusrcb=10, indecode. MEMADR: alusrca=10, alusrcb=10.
- MREAD, MVALID: iord. MWB: regwrite, regsrc=001. FMWB: fregwrite.
- MWRITE: memwrite, iord, iorf=(op==FSW).
- EXEC: alusrca=10, aluop=100. IEXEC: alusrca=10, alusrcb=10, aluop=101.
- ALUWB, IWB, AUIPCS: regwrite. LUIS: regwrite, regsrc=010.
- BRANCH: alusrca=10, pcsrc=01, branch, aluop=111.
- JALS: pcwrite, regwrite, regsrc=011, pcsrc=01.
- JALRS: pcwrite, regwrite, alusrca=10, alusrcb=10, regsrc=011, pcsrc=10.
- SEND_GO: uart_go, rors. RECV_GO: uart_go. RECV_WB: regwrite, regsrc=100.
- FWAIT, SEND_WAIT, RECV_WAIT, FEXEC: all outputs 0.
REQ-024 steps SHALL increment by 1 at each clock edge with state==FETCH and wrap modulo 2^STEP_W.
REQ-025 An unreachable state encoding SHALL drive all outputs 0 and go to FETCH.

Reset
REQ-026 While rstn=0, the block SHALL be in FETCH, with counter=0, steps=0 and timeout_err=0, taking effect immediately and asynchronously, including mid-sequence.
REQ-027 The first rising edge after rstn rises SHALL act as a normal FETCH cycle.

Verification
REQ-028 MEM_LAT=2, LW: states FETCH, FWAIT, FVALID, DECODE, MEMADR, MREAD x2, MVALID, MWB -> regwrite=1 with regsrc=001 in cycle 9, steps=1.
REQ-029 MEM_LAT=1 and MEM_LAT=4, FSW: FWAIT lasts 0 and 3 cycles respectively; MWRITE has memwrite=iord=iorf=1.
REQ-030 RTYPE with rest_instr=0: DECODE -> FETCH, no regwrite pulse; RTYPE with rest_instr!=0 -> EXEC (aluop=100) -> ALUWB.
REQ-031 WAIT_TO=5, RECVB, uart_done held 0: exit to FETCH after 5 wait cycles, timeout_err=1, no regwrite; uart_done=1 in cycle 5 -> RECV_WB instead.
REQ-032 STEP_W=4: after 16 fetches steps=0; rstn pulsed low during MREAD -> immediate FETCH, steps=0, timeout_err=0.
